// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer between the multicycle core and a word RAM.
// Handles wait states, store lane steering, load extension and fault checks.
module mem_access_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [31:0]           byte_addr_i,
  input  logic [DATA_WIDTH-1:0] wd_i,
  input  logic [2:0]            funct3_i,
  input  logic                  mrd_i,
  input  logic                  mwr_i,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  busy_o,
  output logic                  fault_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_be_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wd_q, wd_d;
  logic [2:0]            f3_q, f3_d;
  logic                  wr_q, wr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           rd_q, rd_d;
  logic                  fault_q, fault_d;

  logic                  req;
  logic                  req_fault;
  logic [31:0]           rsh;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           load_ext;
  logic [31:0]           st_data;
  logic [3:0]            st_be;
  logic                  unused_bits;

  function automatic logic is_fault(
    input logic [2:0] f3,
    input logic [1:0] a,
    input logic       wr
  );
    logic bad;
    bad = 1'b0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
      bad = 1'b1;
    if (f3[1:0] == 2'b01 && a[0])
      bad = 1'b1;
    if (f3 == 3'b010 && a != 2'b00)
      bad = 1'b1;
    if (wr && f3[2])
      bad = 1'b1;
    return bad;
  endfunction

  assign req       = mrd_i | mwr_i;
  assign req_fault = is_fault(funct3_i,
                              byte_addr_i[1:0],
                              mwr_i);

  assign unused_bits = ^{byte_addr_i[31:ADDR_WIDTH],
                         rsh[31:8]};

  // Load lane select and extension
  assign rsh    = mem_rdata_i >> {addr_q[1:0], 3'b000};
  assign lane_b = rsh[7:0];
  assign lane_h = addr_q[1] ? mem_rdata_i[31:16]
                            : mem_rdata_i[15:0];

  always_comb begin
    load_ext = mem_rdata_i;
    unique case (1'b1)
      (f3_q == 3'b000): load_ext = {{24{lane_b[7]}}, lane_b};
      (f3_q == 3'b100): load_ext = {24'h0, lane_b};
      (f3_q == 3'b001): load_ext = {{16{lane_h[15]}}, lane_h};
      (f3_q == 3'b101): load_ext = {16'h0, lane_h};
      default:          load_ext = mem_rdata_i;
    endcase
  end

  // Store lane replication and byte enables
  always_comb begin
    st_data = wd_q;
    st_be   = 4'b1111;
    unique case (1'b1)
      (f3_q[1:0] == 2'b00): begin
        st_data = {4{wd_q[7:0]}};
        st_be   = 4'b0001 << addr_q[1:0];
      end
      (f3_q[1:0] == 2'b01): begin
        st_data = {2{wd_q[15:0]}};
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = wd_q;
        st_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    fault_d = fault_q;
    busy_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          busy_o = 1'b1;
          addr_d = byte_addr_i[ADDR_WIDTH-1:0];
          wd_d   = wd_i;
          f3_d   = funct3_i;
          wr_d   = mwr_i;
          if (req_fault) begin
            fault_d = 1'b1;
            rd_d    = '0;
            state_d = S_DONE;
          end else begin
            fault_d = 1'b0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        busy_o  = 1'b1;
        cnt_d   = 3'(WAIT_STATES);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        if (cnt_q == 3'd0) begin
          if (!wr_q)
            rd_d = load_ext;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DONE: begin
        if (!req)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      fault_q <= fault_d;
    end
  end

  assign rd_o        = rd_q;
  assign fault_o     = fault_q;
  assign mem_addr_o  = addr_q[ADDR_WIDTH-1:2];
  assign mem_re_o    = (state_q == S_ACCESS) && !wr_q;
  assign mem_we_o    = (state_q == S_ACCESS) && wr_q;
  assign mem_be_o    = mem_we_o ? st_be : 4'b0000;
  assign mem_wdata_o = st_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word RAM.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [31:0] byte_addr;
  logic [31:0] wd;
  logic [2:0]  funct3;
  logic        mrd, mwr;
  logic [31:0] rd_o;
  logic        busy_o, fault_o;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (12),
    .WAIT_STATES(1)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .byte_addr_i(byte_addr),
    .wd_i       (wd),
    .funct3_i   (funct3),
    .mrd_i      (mrd),
    .mwr_i      (mwr),
    .rd_o       (rd_o),
    .busy_o     (busy_o),
    .fault_o    (fault_o),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_be_o   (mem_be),
    .mem_re_o   (mem_re),
    .mem_we_o   (mem_we),
    .mem_rdata_i(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b])
          ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_re)
      mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [31:0] erd;
    logic        eflt;
    logic [3:0]  ebe;
    logic [31:0] ewd;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int hold);
    int cyc, nre, nwe;
    logic [9:0]  ma_s;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    logic        hold_busy;
    mrd       = v.rd;
    mwr       = v.wr;
    byte_addr = {20'hABCDE, v.addr};
    wd        = v.wd;
    funct3    = v.f3;
    cyc = 0; nre = 0; nwe = 0;
    ma_s = '0; be_s = '0; wd_s = '0;
    hold_busy = 1'b0;
    #1;
    chk("busy_c0", 32'(busy_o), 32'd1);
    while (busy_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_re) begin
        nre++;
        ma_s = mem_addr;
      end
      if (mem_we) begin
        nwe++;
        ma_s = mem_addr;
        be_s = mem_be;
        wd_s = mem_wdata;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (mem_re) nre++;
      if (mem_we) nwe++;
      if (busy_o) hold_busy = 1'b1;
    end
    chk("done_cycle", 32'(cyc), v.eflt ? 32'd1 : 32'd4);
    chk("rd_o", rd_o, v.erd);
    chk("fault_o", 32'(fault_o), 32'(v.eflt));
    chk("re_pulses", 32'(nre),
        (v.eflt || v.wr) ? 32'd0 : 32'd1);
    chk("we_pulses", 32'(nwe),
        (!v.eflt && v.wr) ? 32'd1 : 32'd0);
    if (!v.eflt)
      chk("mem_addr", 32'(ma_s), 32'(v.addr[11:2]));
    if (!v.eflt && v.wr) begin
      chk("mem_be", 32'(be_s), 32'(v.ebe));
      chk("mem_wdata", wd_s, v.ewd);
    end
    if (hold > 0)
      chk("hold_busy", 32'(hold_busy), 32'd0);
    mrd = 1'b0;
    mwr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t hv;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[0] = 32'h7F00_0001;
    ram[1] = 32'h8899_AABB;
    mem_rdata = '0;
    //        rd    wr    addr     wd            f3      erd           flt   be       ewd
    vecs[0]  = '{1'b1, 1'b0, 12'h004, 32'h0,         3'b010, 32'h8899AABB, 1'b0, 4'h0,    32'h0};
    vecs[1]  = '{1'b1, 1'b0, 12'h007, 32'h0,         3'b000, 32'hFFFFFF88, 1'b0, 4'h0,    32'h0};
    vecs[2]  = '{1'b1, 1'b0, 12'h007, 32'h0,         3'b100, 32'h00000088, 1'b0, 4'h0,    32'h0};
    vecs[3]  = '{1'b1, 1'b0, 12'h006, 32'h0,         3'b001, 32'hFFFF8899, 1'b0, 4'h0,    32'h0};
    vecs[4]  = '{1'b1, 1'b0, 12'h004, 32'h0,         3'b101, 32'h0000AABB, 1'b0, 4'h0,    32'h0};
    vecs[5]  = '{1'b0, 1'b1, 12'h00A, 32'h123456C3,  3'b000, 32'h0000AABB, 1'b0, 4'b0100, 32'hC3C3C3C3};
    vecs[6]  = '{1'b0, 1'b1, 12'h00A, 32'h0000BEEF,  3'b001, 32'h0000AABB, 1'b0, 4'b1100, 32'hBEEFBEEF};
    vecs[7]  = '{1'b0, 1'b1, 12'h008, 32'hDEADBEEF,  3'b010, 32'h0000AABB, 1'b0, 4'b1111, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 1'b0, 12'h008, 32'h0,         3'b010, 32'hDEADBEEF, 1'b0, 4'h0,    32'h0};
    vecs[9]  = '{1'b1, 1'b0, 12'h002, 32'h0,         3'b010, 32'h00000000, 1'b1, 4'h0,    32'h0};
    vecs[10] = '{1'b1, 1'b0, 12'h005, 32'h0,         3'b000, 32'hFFFFFFAA, 1'b0, 4'h0,    32'h0};
    vecs[11] = '{1'b0, 1'b1, 12'h003, 32'h1234,      3'b001, 32'h00000000, 1'b1, 4'h0,    32'h0};
    vecs[12] = '{1'b1, 1'b0, 12'h002, 32'h0,         3'b001, 32'h00007F00, 1'b0, 4'h0,    32'h0};
    vecs[13] = '{1'b1, 1'b0, 12'h000, 32'h0,         3'b011, 32'h00000000, 1'b1, 4'h0,    32'h0};
    vecs[14] = '{1'b0, 1'b1, 12'h000, 32'h55,        3'b100, 32'h00000000, 1'b1, 4'h0,    32'h0};
    vecs[15] = '{1'b1, 1'b1, 12'h010, 32'hCAFEF00D,  3'b010, 32'h00000000, 1'b0, 4'b1111, 32'hCAFEF00D};

    reset_ni  = 1'b0;
    mrd       = 1'b0;
    mwr       = 1'b0;
    byte_addr = '0;
    wd        = '0;
    funct3    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", rd_o, 32'h0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_strobes", {28'h0, mem_be}
        | 32'({mem_re, mem_we}), 32'h0);
    chk("rst_maddr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    reset_ni = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      run(vecs[i], 0);

    // hold request 5 cycles past DONE: single read, no retrigger
    hv = '{1'b1, 1'b0, 12'h010, 32'h0, 3'b010,
           32'hCAFEF00D, 1'b0, 4'h0, 32'h0};
    run(hv, 5);

    // async reset in the middle of a write's WAIT phase
    mwr       = 1'b1;
    byte_addr = 32'h0000_000C;
    wd        = 32'h1111_1111;
    funct3    = 3'b010;
    @(posedge clk); #1;
    chk("wr_access", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    reset_ni = 1'b0;
    #1;
    chk("arst_we", 32'(mem_we), 32'd0);
    chk("arst_rd", rd_o, 32'h0);
    chk("arst_fault", 32'(fault_o), 32'd0);
    chk("arst_maddr", 32'(mem_addr), 32'h0);
    mwr = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    reset_ni = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    run(vecs[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

- Sits between the multicycle core's memory request signals (read/write strobes, byte address, store data, funct3) and a single-port synchronous word-wide data RAM.
- Sequences each access through a small FSM with configurable wait states.
- Drives the core's memory-busy input, so the control matrix stalls until the access completes.
- Performs byte-lane steering and byte enables for stores, and lane select plus sign/zero extension for loads; misaligned or illegal-width accesses are flagged as faults without touching memory.

## Interface
- DATA_WIDTH, 32, data path width (only 32 supported)
- ADDR_WIDTH, 12, byte-address bits decoded; RAM word address is ADDR_WIDTH-2 bits
- WAIT_STATES, 1, extra RAM cycles beyond the base 1-cycle read latency (0..7)

Ports:
- clk_i  in  1  system clock, all state on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- byte_addr_i  in  32  byte address from the core's address mux; bits above ADDR_WIDTH ignored
- wd_i  in  32  store data (rs2 value)
- funct3_i  in  3  access width/sign code (RV32I load/store funct3)
- mrd_i  in  1  read request, held by core until busy_o drops
- mwr_i  in  1  write request, held by core until busy_o drops
- rd_o  out  32  extended load data, valid in DONE
- busy_o  out  1  access in progress (combinational)
- fault_o  out  1  misaligned or illegal funct3, valid in DONE
- mem_addr_o  out  ADDR_WIDTH-2  RAM word address
- mem_wdata_o  out  32  lane-replicated store data
- mem_be_o  out  4  byte enables
- mem_re_o  out  1  RAM read strobe
- mem_we_o  out  1  RAM write strobe
- mem_rdata_i  in  32  RAM read data, valid the cycle after mem_re_o (plus wait states)

## Operation
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - On mrd_i|mwr_i, latch addr, wd, funct3 and the op (write wins if both are set).
  - Faulting request → DONE. Otherwise → ACCESS.
- Faults:
  - funct3 ∈ {011,110,111}.
  - Half access (001, 101) with addr[0]=1.
  - Word access (010) with addr[1:0]≠0.
  - Stores with funct3[2]=1 are also illegal.
- ACCESS lasts exactly 1 cycle.
  - mem_addr_o = latched addr[ADDR_WIDTH-1:2].
  - Read: mem_re_o=1.
  - Write: mem_we_o=1 with mem_be_o/mem_wdata_o.
  - Next state: WAIT.
- WAIT lasts 1+WAIT_STATES cycles, counted by a down-counter loaded on entry.
  - mem_addr_o stays stable; strobes are 0.
  - On the last WAIT cycle's edge, register the extended load result into rd_o (reads only), then → DONE.
- DONE:
  - busy_o=0; rd_o and fault_o are held.
  - → IDLE when mrd_i=0 and mwr_i=0; otherwise stay (no retrigger).
- Store steering:
  - SB: mem_wdata_o = {4{wd[7:0]}}, mem_be_o = 0001<<addr[1:0].
  - SH: mem_wdata_o = {2{wd[15:0]}}, mem_be_o = addr[1] ? 1100 : 0011.
  - SW: mem_wdata_o = wd, mem_be_o = 1111.
- Load extension (lane selected by addr[1:0]):
  - LB sign-extends, LBU zero-extends.
  - LH/LHU use the lane selected by addr[1].
  - LW is passthrough.
- On a fault:
  - rd_o = 0, fault_o = 1, no strobe is issued.
- For a non-faulting access, fault_o = 0 and rd_o keeps its previous value on writes.

## Timing
- Reset (async, any state):
  - state=IDLE.
  - rd_o=0, fault_o=0, mem_re_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.
  - busy_o follows its combinational rule.
  - An in-flight write aborts immediately and is not retried.
- busy_o = (IDLE & (mrd_i|mwr_i)) | ACCESS | WAIT.
  - The core sees busy in the same cycle it raises the request.
- Latency for a normal access: request sampled at edge 0; ACCESS in cycle 1; WAIT in cycles 2..2+WAIT_STATES; DONE in cycle 3+WAIT_STATES.
  - WAIT_STATES=1: DONE in cycle 4.
- Latency for a faulting access: DONE in cycle 1.
- Request inputs are ignored outside IDLE (values latched at acceptance are used).
- Back-to-back: the minimum gap between accesses is one IDLE cycle after DONE.
- Exactly one mem_re_o or mem_we_o pulse per non-faulting access.

## Test plan
- Reset values:
  - Assert reset_ni=0 mid-WAIT of a write → mem_we_o=0 immediately, state=IDLE, rd_o=0, fault_o=0.
  - After release with no request, busy_o=0.
- Word read, WAIT_STATES=1:
  - RAM word 1 = 0x8899AABB; mrd_i, addr=0x004, funct3=010.
  - Response: one mem_re_o pulse with mem_addr_o=1, busy_o high for cycles 0–3, DONE in cycle 4 with rd_o=0x8899AABB and fault_o=0.
- Byte/half extension, same word:
  - LB addr=0x007 → 0xFFFFFF88.
  - LBU addr=0x007 → 0x00000088.
  - LH addr=0x006 → 0xFFFF8899.
  - LHU addr=0x004 → 0x0000AABB.
- Store steering:
  - SB wd=0x123456C3 addr=0x00A → mem_be_o=0100, mem_wdata_o=0xC3C3C3C3.
  - SH wd=0x0000BEEF addr=0x00A → mem_be_o=1100, mem_wdata_o=0xBEEFBEEF.
  - SW → mem_be_o=1111.
- Faults:
  - LW addr=0x002, SH addr=0x003, and funct3=011 each → DONE in cycle 1 with fault_o=1 and rd_o=0.
  - No mem_re_o or mem_we_o asserted in any of these cases.
- Hold/no-retrigger:
  - Keep mrd_i=1 for 5 cycles after DONE → exactly one mem_re_o pulse and busy_o=0.
  - Drop mrd_i, then raise mwr_i with mrd_i=1 simultaneously → write is performed (mem_we_o pulse, no mem_re_o).
